avst_format_adapter_out: RTL and testbench
==========================================

// Module: avst_format_adapter_out
// PURPOSE
//  Avalon-ST transmit-side format adapter. It is the outbound counterpart of the capture-path input adapter.
//  Accepts wide words (default 24-bit pixel) with packet framing and emits them as narrow symbols
//  (default 8-bit), one symbol per out_ready/out_valid transfer, MSB symbol first.
//  Sits between the Qsys stream source (DMA/FIFO) and a byte-wide Avalon-ST sink (UART/JTAG/off-chip link).
// PARAMETERS
//  IN_WIDTH      24  input data width; must be an integer multiple of SYMBOL_WIDTH
//  SYMBOL_WIDTH   8  output symbol width
//  MSB_FIRST      1  1: symbol 0 = in_data[IN_WIDTH-1 -: SYMBOL_WIDTH]; 0: LSB symbol first
// PORTS
//  clk                in   1             single clock, all logic rising-edge
//  reset              in   1             synchronous, active-high
//  in_ready           out  1             sink ready for a new word
//  in_valid           in   1             word valid
//  in_data            in   IN_WIDTH      word
//  in_startofpacket   in   1             first word of packet
//  in_endofpacket     in   1             last word of packet
//  out_ready          in   1             downstream ready
//  out_valid          out  1             symbol valid
//  out_data           out  SYMBOL_WIDTH  symbol
//  out_startofpacket  out  1             first symbol of packet
//  out_endofpacket    out  1             last symbol of packet
//  pkt_error          out  1             only with AVST_OUT_PKT_CHECK_EN; sticky framing-error flag
// BEHAVIOUR
//  - NSYM = IN_WIDTH/SYMBOL_WIDTH. Word register, held sop/eop, and symbol index sym_idx (0..NSYM-1).
//  - FSM: EMPTY (no word held), SEND (word held, out_valid=1).
//  - Reset: state=EMPTY, sym_idx=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, pkt_error=0.
//  - in_ready = (state==EMPTY) | (out_ready & sym_idx==NSYM-1). This is combinational, with no bubble between words.
//  - Input accept (in_valid & in_ready): latch data and sop/eop, sym_idx<=0, state<=SEND.
//  - Latency: first symbol valid on the cycle after accept. Sustained throughput: 1 word per NSYM cycles.
//  - out_data = symbol sym_idx of the held word. Its order follows MSB_FIRST.
//  - out_startofpacket = held_sop & (sym_idx==0). out_endofpacket = held_eop & (sym_idx==NSYM-1).
//  - Transfer (out_valid & out_ready):
//      sym_idx<NSYM-1: sym_idx++.
//      sym_idx==NSYM-1 with a new accept: reload, go to SEND.
//      sym_idx==NSYM-1 without a new accept: go to EMPTY.
//  - out_ready low: out_data, out_valid, sop and eop are held stable. No symbol is dropped or repeated.
//  - Single-word packet (sop & eop on the same word): sop on symbol 0 and eop on symbol NSYM-1.
//  - NSYM==1: pure registered pass-through with the same handshake.
//  - Reset while in SEND: the held word is discarded, and out_valid drops on the cycle after reset asserts.
//  - in_valid is ignored while in_ready=0. Upstream must hold the word, per Avalon-ST.
// CONFIGURATION
//  - AVST_OUT_PKT_CHECK_EN defined:
//      Adds the pkt_error port and an in_packet tracker that updates on each accepted word.
//      pkt_error sets (sticky until reset) on: sop while in_packet, or a word without sop while not in_packet.
//      An offending word is still forwarded unchanged.
//  - Not defined: no pkt_error port and no tracker logic. Datapath behaviour is identical.
// STRUCTURE
//  - Package avst_adapter_pkg holds the FSM state typedef (EMPTY/SEND) and the NSYM calc/check function.
//    The IN_WIDTH%SYMBOL_WIDTH==0 elaboration check is shared with the input-side adapters.
//  - One sub-module, avst_pkt_checker: the in_packet/pkt_error tracker.
//    It is instantiated only under AVST_OUT_PKT_CHECK_EN and is reusable on other stream ports.
// TESTING
//  1 Single word 0xA1B2C3 with sop=eop=1 and out_ready=1.
//    -> symbols A1, B2, C3 on 3 consecutive cycles; sop with A1, eop with C3; in_ready high on the C3 cycle.
//  2 Back-to-back words 0x112233 then 0x445566, in_valid and out_ready held high.
//    -> 6 consecutive symbols 11..66 with no idle cycle; in_ready high only on cycles 0, 3 and 6.
//  3 out_ready toggles 1,0,0,1 during word 0xDEADBE.
//    -> DE, then AD held stable for 2 cycles, then BE; no duplicate or lost symbol.
//  4 Reset asserted while sym_idx=1 of word 0x010203.
//    -> out_valid=0 on the next cycle, in_ready=1, and no remaining symbols appear after reset.
//  5 MSB_FIRST=0 with word 0xA1B2C3 -> symbols C3, B2, A1.
//  6 With AVST_OUT_PKT_CHECK_EN, send two sop words without an eop between them.
//    -> pkt_error=1 from the cycle after the second accept and stays 1; all 6 symbols still emitted.

Source files
------------

// File: rtl/avst_adapter_pkg.sv
// avst_adapter_pkg
//   Shared definitions for the Avalon-ST format adapters (input and output side).
//   - adapter_state_t : two-state word-holding FSM encoding (EMPTY / SEND)
//   - calc_nsym()     : number of narrow symbols carried by one wide word
//   - width_ok()      : true when the wide width is an exact multiple of the symbol width
package avst_adapter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } adapter_state_t;

  function automatic int calc_nsym(input int in_width, input int symbol_width);
    return in_width / symbol_width;
  endfunction

  function automatic bit width_ok(input int in_width, input int symbol_width);
    return (symbol_width > 0) && (in_width >= symbol_width) &&
           ((in_width % symbol_width) == 0);
  endfunction

endpackage

// File: rtl/avst_format_adapter_out_if.sv
// avst_format_adapter_out_if
//   Bundles both stream ports of the transmit-side format adapter.
//   Parameters: IN_WIDTH (wide word width), SYMBOL_WIDTH (narrow symbol width).
//   Signals: in_ready/in_valid/in_data/in_startofpacket/in_endofpacket (wide side),
//            out_ready/out_valid/out_data/out_startofpacket/out_endofpacket (narrow side).
//   Modports: slave  - the adapter itself (consumes wide words, produces symbols)
//             master - the surrounding environment (source upstream, sink downstream)
interface avst_format_adapter_out_if #(
  parameter int IN_WIDTH     = 24,
  parameter int SYMBOL_WIDTH = 8
);

  logic                    in_ready;
  logic                    in_valid;
  logic [IN_WIDTH-1:0]     in_data;
  logic                    in_startofpacket;
  logic                    in_endofpacket;
  logic                    out_ready;
  logic                    out_valid;
  logic [SYMBOL_WIDTH-1:0] out_data;
  logic                    out_startofpacket;
  logic                    out_endofpacket;

  modport slave (
    output in_ready,
    input  in_valid, in_data, in_startofpacket, in_endofpacket,
    input  out_ready,
    output out_valid, out_data, out_startofpacket, out_endofpacket
  );

  modport master (
    input  in_ready,
    output in_valid, in_data, in_startofpacket, in_endofpacket,
    output out_ready,
    input  out_valid, out_data, out_startofpacket, out_endofpacket
  );

endinterface

// File: rtl/avst_pkt_checker.sv
// avst_pkt_checker
//   Tracks packet framing on any Avalon-ST port and raises a sticky error flag.
//   Ports: clk, reset (synchronous, active-high)
//          accept    - one word transferred this cycle (valid & ready)
//          sop, eop  - framing bits of that word
//          pkt_error - sticky until reset: sop inside a packet, or a non-sop word outside one
module avst_pkt_checker (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  input  logic sop,
  input  logic eop,
  output logic pkt_error
);

  logic in_packet_q, in_packet_d;
  logic pkt_error_q, pkt_error_d;

  // Any accepted word without eop leaves us inside a packet, including an
  // offending headless word, so the tracker resynchronises on the next eop.
  always_comb begin
    in_packet_d = in_packet_q;
    pkt_error_d = pkt_error_q;
    if (accept) begin
      in_packet_d = !eop;
      if ((sop && in_packet_q) || (!sop && !in_packet_q)) begin
        pkt_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_packet_q <= 1'b0;
      pkt_error_q <= 1'b0;
    end else begin
      in_packet_q <= in_packet_d;
      pkt_error_q <= pkt_error_d;
    end
  end

  assign pkt_error = pkt_error_q;

endmodule

// File: rtl/avst_format_adapter_out.sv
// avst_format_adapter_out
//   Transmit-side Avalon-ST format adapter: takes wide framed words and emits
//   them as NSYM = IN_WIDTH/SYMBOL_WIDTH narrow symbols, one per transfer.
//   Ports: clk, reset (synchronous, active-high)
//          bus       - avst_format_adapter_out_if.slave (wide in_* side, narrow out_* side)
//          pkt_error - only when AVST_OUT_PKT_CHECK_EN is defined; sticky framing error
//   Parameters: IN_WIDTH, SYMBOL_WIDTH, MSB_FIRST (1: most significant symbol goes out first)
//   Optional feature macro: AVST_OUT_PKT_CHECK_EN
module avst_format_adapter_out
  import avst_adapter_pkg::*;
#(
  parameter int IN_WIDTH     = 24,
  parameter int SYMBOL_WIDTH = 8,
  parameter int MSB_FIRST    = 1
) (
  input  logic clk,
  input  logic reset,
  avst_format_adapter_out_if.slave bus
`ifdef AVST_OUT_PKT_CHECK_EN
  ,
  output logic pkt_error
`endif
);

  localparam int NSYM  = calc_nsym(IN_WIDTH, SYMBOL_WIDTH);
  localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

  if (!width_ok(IN_WIDTH, SYMBOL_WIDTH)) begin : g_width_check
    $error("IN_WIDTH must be a non-zero multiple of SYMBOL_WIDTH");
  end

  adapter_state_t          state_q, state_d;
  logic [IDX_W-1:0]        sym_idx_q, sym_idx_d;
  logic [IN_WIDTH-1:0]     word_q, word_d;
  logic                    sop_q, sop_d;
  logic                    eop_q, eop_d;
  logic                    last_sym;
  logic                    in_ready;
  logic                    accept;
  logic [SYMBOL_WIDTH-1:0] sym_data;

  // A new word can be taken while the last symbol of the current one leaves,
  // so a continuous stream has no idle cycle between words.
  always_comb begin
    last_sym = (sym_idx_q == LAST_IDX);
    in_ready = (state_q == EMPTY) || (bus.out_ready && last_sym);
    accept   = bus.in_valid && in_ready;
  end

  // Next-state logic. The accept branch comes last so that a reload on the
  // final symbol overrides the fall-back to EMPTY.
  always_comb begin
    state_d   = state_q;
    sym_idx_d = sym_idx_q;
    word_d    = word_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    if ((state_q == SEND) && bus.out_ready) begin
      if (!last_sym) begin
        sym_idx_d = sym_idx_q + IDX_W'(1);
      end else begin
        state_d   = EMPTY;
        sym_idx_d = '0;
      end
    end
    if (accept) begin
      state_d   = SEND;
      sym_idx_d = '0;
      word_d    = bus.in_data;
      sop_d     = bus.in_startofpacket;
      eop_d     = bus.in_endofpacket;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      sym_idx_q <= '0;
      word_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_idx_q <= sym_idx_d;
      word_q    <= word_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
    end
  end

  // Symbol mux: sym_idx counts transmission order, which maps to a word
  // slice from the top down (MSB first) or from the bottom up.
  always_comb begin
    sym_data = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (sym_idx_q == IDX_W'(i)) begin
        sym_data = word_q[((MSB_FIRST != 0) ? (NSYM - 1 - i) : i) * SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

  always_comb begin
    bus.in_ready          = in_ready;
    bus.out_valid         = (state_q == SEND);
    bus.out_data          = sym_data;
    bus.out_startofpacket = sop_q && (sym_idx_q == '0);
    bus.out_endofpacket   = eop_q && last_sym;
  end

`ifdef AVST_OUT_PKT_CHECK_EN
  avst_pkt_checker u_pkt_checker (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .sop       (bus.in_startofpacket),
    .eop       (bus.in_endofpacket),
    .pkt_error (pkt_error)
  );
`endif

endmodule

// File: tb/tb_avst_format_adapter_out.sv
// tb_avst_format_adapter_out
//   Directed bench for the transmit-side format adapter. Two instances share
//   the same stimulus: dut (MSB first) and dut_lsb (LSB first).
module tb_avst_format_adapter_out;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic        out_ready;

  int check_count;
  int pass_count;

  avst_format_adapter_out_if #(.IN_WIDTH(24), .SYMBOL_WIDTH(8)) bus ();
  avst_format_adapter_out_if #(.IN_WIDTH(24), .SYMBOL_WIDTH(8)) bus_lsb ();

`ifdef AVST_OUT_PKT_CHECK_EN
  logic pkt_error;
  logic pkt_error_lsb;
`endif

  assign bus.in_valid             = in_valid;
  assign bus.in_data              = in_data;
  assign bus.in_startofpacket     = in_sop;
  assign bus.in_endofpacket       = in_eop;
  assign bus.out_ready            = out_ready;
  assign bus_lsb.in_valid         = in_valid;
  assign bus_lsb.in_data          = in_data;
  assign bus_lsb.in_startofpacket = in_sop;
  assign bus_lsb.in_endofpacket   = in_eop;
  assign bus_lsb.out_ready        = out_ready;

  avst_format_adapter_out #(.IN_WIDTH(24), .SYMBOL_WIDTH(8), .MSB_FIRST(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef AVST_OUT_PKT_CHECK_EN
    ,
    .pkt_error (pkt_error)
`endif
  );

  avst_format_adapter_out #(.IN_WIDTH(24), .SYMBOL_WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lsb)
`ifdef AVST_OUT_PKT_CHECK_EN
    ,
    .pkt_error (pkt_error_lsb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check_count++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", bus.out_valid);
    else pass_count++;
    check_count++;
    if (bus.out_data !== 8'h00) $display("[TB] FAIL reset_out_data got %02h want 00", bus.out_data);
    else pass_count++;
    check_count++;
    if ({bus.out_startofpacket, bus.out_endofpacket} !== 2'b00)
      $display("[TB] FAIL reset_sop_eop got %02b want 00", {bus.out_startofpacket, bus.out_endofpacket});
    else pass_count++;
    check_count++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %0b want 1", bus.in_ready);
    else pass_count++;
`ifdef AVST_OUT_PKT_CHECK_EN
    check_count++;
    if (pkt_error !== 1'b0) $display("[TB] FAIL reset_pkt_error got %0b want 0", pkt_error);
    else pass_count++;
`endif
  endtask

  task automatic test_single_word();
    logic [7:0] exp_sym [3];
    exp_sym = '{8'hA1, 8'hB2, 8'hC3};
    in_valid  = 1'b1;
    in_data   = 24'hA1B2C3;
    in_sop    = 1'b1;
    in_eop    = 1'b1;
    out_ready = 1'b1;
    #1;
    check_count++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL single_ready_idle got %0b want 1", bus.in_ready);
    else pass_count++;
    step();
    in_valid = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check_count++;
      if ({bus.out_valid, bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.in_ready} !==
          {1'b1, exp_sym[c], (c == 0), (c == 2), (c == 2)})
        $display("[TB] FAIL single_sym%0d got v=%0b d=%02h sop=%0b eop=%0b rdy=%0b want v=1 d=%02h sop=%0b eop=%0b rdy=%0b",
                 c, bus.out_valid, bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.in_ready,
                 exp_sym[c], (c == 0), (c == 2), (c == 2));
      else pass_count++;
      step();
    end
    check_count++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL single_idle_after got %0b want 0", bus.out_valid);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_sym [6];
    exp_sym = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    in_valid  = 1'b1;
    in_data   = 24'h112233;
    in_sop    = 1'b1;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    #1;
    check_count++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_c0 got %0b want 1", bus.in_ready);
    else pass_count++;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        in_data = 24'h445566;
        in_sop  = 1'b0;
        in_eop  = 1'b1;
      end
      if (c == 4) in_valid = 1'b0;
      #1;
      check_count++;
      if ({bus.out_valid, bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.in_ready} !==
          {1'b1, exp_sym[c-1], (c == 1), (c == 6), (c == 3 || c == 6)})
        $display("[TB] FAIL b2b_c%0d got v=%0b d=%02h sop=%0b eop=%0b rdy=%0b want v=1 d=%02h sop=%0b eop=%0b rdy=%0b",
                 c, bus.out_valid, bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.in_ready,
                 exp_sym[c-1], (c == 1), (c == 6), (c == 3 || c == 6));
      else pass_count++;
    end
    step();
    check_count++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_idle_after got %0b want 0", bus.out_valid);
    else pass_count++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_sym [5];
    logic       rdy_pat [5];
    exp_sym = '{8'hDE, 8'hAD, 8'hAD, 8'hAD, 8'hBE};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    in_valid  = 1'b1;
    in_data   = 24'hDEADBE;
    in_sop    = 1'b1;
    in_eop    = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      out_ready = rdy_pat[c];
      #1;
      check_count++;
      if ({bus.out_valid, bus.out_data, bus.out_startofpacket, bus.out_endofpacket} !==
          {1'b1, exp_sym[c], (c == 0), (c == 4)})
        $display("[TB] FAIL bp_c%0d got v=%0b d=%02h sop=%0b eop=%0b want v=1 d=%02h sop=%0b eop=%0b",
                 c, bus.out_valid, bus.out_data, bus.out_startofpacket, bus.out_endofpacket,
                 exp_sym[c], (c == 0), (c == 4));
      else pass_count++;
      step();
    end
    check_count++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_idle_after got %0b want 0", bus.out_valid);
    else pass_count++;
  endtask

  task automatic test_reset_mid_word();
    in_valid  = 1'b1;
    in_data   = 24'h010203;
    in_sop    = 1'b1;
    in_eop    = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_count++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h02})
      $display("[TB] FAIL rst_mid_pre got v=%0b d=%02h want v=1 d=02", bus.out_valid, bus.out_data);
    else pass_count++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_count++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("[TB] FAIL rst_mid_post got v=%0b rdy=%0b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    else pass_count++;
    for (int c = 0; c < 3; c++) begin
      step();
      check_count++;
      if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_mid_leftover%0d got %0b want 0", c, bus.out_valid);
      else pass_count++;
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_sym [3];
    exp_sym = '{8'hC3, 8'hB2, 8'hA1};
    in_valid  = 1'b1;
    in_data   = 24'hA1B2C3;
    in_sop    = 1'b1;
    in_eop    = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check_count++;
      if ({bus_lsb.out_valid, bus_lsb.out_data, bus_lsb.out_startofpacket, bus_lsb.out_endofpacket} !==
          {1'b1, exp_sym[c], (c == 0), (c == 2)})
        $display("[TB] FAIL lsb_sym%0d got v=%0b d=%02h sop=%0b eop=%0b want v=1 d=%02h sop=%0b eop=%0b",
                 c, bus_lsb.out_valid, bus_lsb.out_data, bus_lsb.out_startofpacket, bus_lsb.out_endofpacket,
                 exp_sym[c], (c == 0), (c == 2));
      else pass_count++;
      step();
    end
  endtask

`ifdef AVST_OUT_PKT_CHECK_EN
  task automatic test_pkt_check();
    logic [7:0] exp_sym [6];
    exp_sym = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    in_valid  = 1'b1;
    in_data   = 24'h112233;
    in_sop    = 1'b1;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) in_data = 24'h445566;
      if (c == 4) in_valid = 1'b0;
      #1;
      check_count++;
      if ({bus.out_valid, bus.out_data, pkt_error} !== {1'b1, exp_sym[c-1], (c >= 4)})
        $display("[TB] FAIL pkt_c%0d got v=%0b d=%02h err=%0b want v=1 d=%02h err=%0b",
                 c, bus.out_valid, bus.out_data, pkt_error, exp_sym[c-1], (c >= 4));
      else pass_count++;
    end
    step();
    step();
    check_count++;
    if (pkt_error !== 1'b1) $display("[TB] FAIL pkt_sticky got %0b want 1", pkt_error);
    else pass_count++;
  endtask
`endif

  initial begin
    check_count = 0;
    pass_count  = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_lsb_first();
`ifdef AVST_OUT_PKT_CHECK_EN
    test_pkt_check();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
